// File: rtl/key_bounce_gen_pkg.sv
// key_bounce_gen_pkg
//   Shared definitions for the bouncing push-button generator:
//   FSM state encoding, LFSR geometry and the idle key level.
package key_bounce_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESS   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_SETTLE  = 3'd4
    } state_t;

    localparam int               LFSR_W    = 8;
    // taps 8,6,5,4 -> bits 7,5,4,3
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic             KEY_IDLE  = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_bounce_gen_if.sv
// key_bounce_gen_if
//   Control/status bundle of the key bounce generator.
//   start   : request one press/release sequence (master -> slave)
//   abort   : terminate the running sequence     (master -> slave)
//   key_out : emulated key level, active-low      (slave -> master)
//   busy    : sequence in progress                (slave -> master)
//   done    : one-cycle completion pulse          (slave -> master)
interface key_bounce_gen_if;
    logic start;
    logic abort;
    logic key_out;
    logic busy;
    logic done;

    modport master (output start, abort, input key_out, busy, done);
    modport slave  (input start, abort, output key_out, busy, done);
endinterface

// File: rtl/key_bounce_gen_lfsr8_step.sv
// lfsr8_step
//   Free-standing 8-bit Fibonacci LFSR (taps 8,6,5,4), shifting left with
//   the feedback bit entering bit 0. Advances only when i_adv is high.
//   clk    : clock
//   rst    : synchronous active-high reset, loads SEED
//   i_adv  : advance one step
//   o_lfsr : current register value
module lfsr8_step
    import key_bounce_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_adv,
    output logic [LFSR_W-1:0] o_lfsr
);

    logic [LFSR_W-1:0] r_lfsr;
    logic              w_fb;

    assign w_fb   = ^(r_lfsr & LFSR_TAPS);
    assign o_lfsr = r_lfsr;

    always_ff @(posedge clk) begin
        if (rst)        r_lfsr <= SEED;
        else if (i_adv) r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
    end

endmodule

// File: rtl/key_bounce_gen.sv
// key_bounce_gen
//   Emits one bouncing active-low key press per start request: a burst of
//   2*BOUNCE_N+1 toggles ending low, a stable hold, a release burst ending
//   high, then a stable settle followed by a one-cycle done pulse.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : key_bounce_gen_if.slave (start, abort in; key_out, busy, done out)
module key_bounce_gen
    import key_bounce_gen_pkg::*;
#(
    parameter int                BOUNCE_N   = 3,
    parameter int                GAP_W      = 2,
    parameter int                FIXED_GAP  = 0,
    parameter int                HOLD_CYC   = 16,
    parameter int                SETTLE_CYC = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    key_bounce_gen_if.slave  bus
);

    localparam int CNT_MAX = max2(max2(HOLD_CYC, SETTLE_CYC), max2(1 << GAP_W, FIXED_GAP));
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int TOG_W   = $clog2(2 * BOUNCE_N + 2);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_HOLD   = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] C_SETTLE = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] C_FIXED  = CNT_W'(FIXED_GAP);
    // r_tog holds the number of toggles already made in the burst
    localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * BOUNCE_N);

    state_t            r_state, w_state_nx;
    logic              r_key,   w_key_nx;
    logic              r_busy,  w_busy_nx;
    logic              r_done,  w_done_nx;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nx;
    logic [TOG_W-1:0]  r_tog,   w_tog_nx;
    logic              w_adv;
    logic [LFSR_W-1:0] w_lfsr;
    logic [CNT_W-1:0]  w_gap;

    lfsr8_step #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_adv  (w_adv),
        .o_lfsr (w_lfsr)
    );

    assign w_gap = (FIXED_GAP != 0) ? C_FIXED
                                    : CNT_W'(w_lfsr[GAP_W-1:0]) + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_key   <= KEY_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_tog   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_key   <= w_key_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_cnt   <= w_cnt_nx;
            r_tog   <= w_tog_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_key_nx   = r_key;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_cnt_nx   = r_cnt;
        w_tog_nx   = r_tog;
        w_adv      = 1'b0;

        if (r_state != ST_IDLE && bus.abort) begin
            w_state_nx = ST_IDLE;
            w_key_nx   = KEY_IDLE;
            w_busy_nx  = 1'b0;
            w_cnt_nx   = '0;
            w_tog_nx   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_key_nx  = KEY_IDLE;
                    w_busy_nx = 1'b0;
                    if (bus.start) begin
                        w_state_nx = ST_PRESS;
                        w_busy_nx  = 1'b1;
                        w_key_nx   = ~KEY_IDLE;
                        w_tog_nx   = TOG_W'(1);
                        w_cnt_nx   = w_gap;
                        w_adv      = 1'b1;
                    end
                end
                ST_PRESS, ST_RELEASE: begin
                    if (r_cnt == CNT_ONE) begin
                        w_key_nx = ~r_key;
                        if (r_tog == TOG_LAST) begin
                            // final toggle of the burst: go straight to the stable phase
                            w_tog_nx = '0;
                            if (r_state == ST_PRESS) begin
                                w_state_nx = ST_HOLD;
                                w_cnt_nx   = C_HOLD;
                            end else begin
                                w_state_nx = ST_SETTLE;
                                w_cnt_nx   = C_SETTLE;
                            end
                        end else begin
                            w_tog_nx = r_tog + TOG_W'(1);
                            w_cnt_nx = w_gap;
                            w_adv    = 1'b1;
                        end
                    end else begin
                        w_cnt_nx = r_cnt - CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == CNT_ONE) begin
                        w_state_nx = ST_RELEASE;
                        w_key_nx   = KEY_IDLE;
                        w_tog_nx   = TOG_W'(1);
                        w_cnt_nx   = w_gap;
                        w_adv      = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt - CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == CNT_ONE) begin
                        w_state_nx = ST_IDLE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_key_nx   = KEY_IDLE;
                    w_busy_nx  = 1'b0;
                end
            endcase
        end
    end

    assign bus.key_out = r_key;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_key_bounce_gen.sv
// tb_key_bounce_gen
//   Directed bench: a fixed-gap instance (G=3, B=2, hold 16, settle 8) with
//   hand-computed toggle cycles, and a default random-gap instance checked
//   for burst shape, first LFSR-derived gaps and reproducibility after reset.
module tb_key_bounce_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_bounce_gen_if fif();
    key_bounce_gen_if rif();

    key_bounce_gen #(
        .BOUNCE_N(2), .GAP_W(2), .FIXED_GAP(3),
        .HOLD_CYC(16), .SETTLE_CYC(8), .LFSR_SEED(8'hA5)
    ) dut_f (.clk(clk), .rst(rst), .bus(fif));

    key_bounce_gen dut_r (.clk(clk), .rst(rst), .bus(rif));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
    endtask

    // key level of the fixed-gap instance c cycles into a sequence
    function automatic logic fx_key(input int c);
        int   tg [10] = '{1, 4, 7, 10, 13, 29, 32, 35, 38, 41};
        logic k = 1'b1;
        foreach (tg[i]) if (c >= tg[i]) k = ~k;
        return k;
    endfunction

    task automatic run_fixed(input string tag, input logic ab);
        fif.start = 1'b1;
        fif.abort = ab;
        tick;
        fif.start = 1'b0;
        fif.abort = 1'b0;
        for (int c = 1; c <= 55; c++) begin
            chk({tag, "_key"},  32'(fif.key_out), 32'(fx_key(c)));
            chk({tag, "_busy"}, 32'(fif.busy),    32'(c >= 1 && c <= 48));
            chk({tag, "_done"}, 32'(fif.done),    32'(c == 49));
            tick;
        end
    endtask

    task automatic run_rnd(output int tt[14], output int ntog, output int tdone);
        logic prev;
        prev  = 1'b1;
        ntog  = 0;
        tdone = -1;
        foreach (tt[i]) tt[i] = 0;
        rif.start = 1'b1;
        tick;
        rif.start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (rif.key_out !== prev) begin
                if (ntog < 14) tt[ntog] = c;
                ntog++;
                prev = rif.key_out;
            end
            if (rif.done === 1'b1) begin
                tdone = c;
                break;
            end
            tick;
        end
    endtask

    int   ta [14];
    int   tb [14];
    int   na, nb, da, db;
    logic seen;

    initial begin
        fif.start = 1'b0; fif.abort = 1'b0;
        rif.start = 1'b0; rif.abort = 1'b0;

        // reset state, then idle with start low
        do_reset;
        chk("rst_key",  32'(fif.key_out), 32'd1);
        chk("rst_busy", 32'(fif.busy),    32'd0);
        chk("rst_done", 32'(fif.done),    32'd0);
        chk("rst_rkey", 32'(rif.key_out), 32'd1);
        chk("rst_rbusy", 32'(rif.busy),   32'd0);
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("idle_key",  32'(fif.key_out), 32'd1);
            chk("idle_busy", 32'(fif.busy),    32'd0);
            chk("idle_done", 32'(fif.done),    32'd0);
        end

        // fixed-gap full sequence
        run_fixed("fx", 1'b0);

        // abort mid-press at toggle 3
        fif.start = 1'b1; tick; fif.start = 1'b0;   // c=1
        repeat (6) tick;                             // c=7
        chk("ab_pre_key",  32'(fif.key_out), 32'd0);
        chk("ab_pre_busy", 32'(fif.busy),    32'd1);
        fif.abort = 1'b1; tick; fif.abort = 1'b0;   // c=8
        chk("ab_key",  32'(fif.key_out), 32'd1);
        chk("ab_busy", 32'(fif.busy),    32'd0);
        chk("ab_done", 32'(fif.done),    32'd0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick;
            if (fif.done !== 1'b0 || fif.busy !== 1'b0) seen = 1'b1;
        end
        chk("ab_quiet", 32'(seen), 32'd0);

        // abort in idle has no effect
        fif.abort = 1'b1; tick; fif.abort = 1'b0;
        chk("ab_idle_key",  32'(fif.key_out), 32'd1);
        chk("ab_idle_busy", 32'(fif.busy),    32'd0);

        // full run after abort; start together with abort in idle: start wins
        run_fixed("fx2", 1'b1);

        // start held high across completion: back-to-back sequences
        fif.start = 1'b1;
        tick;
        for (int c = 1; c <= 100; c++) begin
            chk("b2b_done", 32'(fif.done), 32'(c == 49 || c == 98));
            chk("b2b_busy", 32'(fif.busy), 32'(!(c == 49 || c == 98)));
            if (c == 50) chk("b2b_key50", 32'(fif.key_out), 32'd0);
            tick;
        end
        fif.start = 1'b0;
        fif.abort = 1'b1; tick; fif.abort = 1'b0;
        chk("b2b_abort_busy", 32'(fif.busy), 32'd0);

        // random gaps, default parameters
        run_rnd(ta, na, da);
        chk("rnd_ntog",  32'(na), 32'd14);
        chk("rnd_done",  32'(da >= 0), 32'd1);
        if (na == 14 && da >= 0) begin
            chk("rnd_t0",   32'(ta[0]), 32'd1);
            chk("rnd_gap0", 32'(ta[1] - ta[0]), 32'd2);
            chk("rnd_gap1", 32'(ta[2] - ta[1]), 32'd3);
            chk("rnd_gap2", 32'(ta[3] - ta[2]), 32'd2);
            for (int i = 0; i < 13; i++) begin
                if (i != 6)
                    chk("rnd_gap_rng", 32'((ta[i+1] - ta[i]) >= 1 && (ta[i+1] - ta[i]) <= 4), 32'd1);
            end
            chk("rnd_hold",   32'(ta[7] - ta[6]), 32'd16);
            chk("rnd_settle", 32'(da - ta[13]),   32'd8);
        end
        chk("rnd_end_key", 32'(rif.key_out), 32'd1);

        // second run after reset reproduces the same waveform
        tick;
        do_reset;
        run_rnd(tb, nb, db);
        chk("rep_ntog", 32'(nb), 32'(na));
        chk("rep_done", 32'(db), 32'(da));
        for (int i = 0; i < 14; i++) chk("rep_t", 32'(tb[i]), 32'(ta[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
